// File: rtl/snake_pkg.sv
// Shared direction encodings, FSM states and direction helpers for the snake game.
// rect_controller imports this package as well.
package snake_pkg;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [3:0] opposite(input logic [3:0] dir);
    logic [3:0] res;
    case (dir)
      DIR_UP:    res = DIR_DOWN;
      DIR_DOWN:  res = DIR_UP;
      DIR_LEFT:  res = DIR_RIGHT;
      DIR_RIGHT: res = DIR_LEFT;
      default:   res = 4'b0000;
    endcase
    return res;
  endfunction

  // Simultaneous presses collapse to one request: UP > DOWN > LEFT > RIGHT.
  function automatic logic [3:0] priority_pick(input logic [3:0] req);
    logic [3:0] res;
    if (req[0])      res = DIR_UP;
    else if (req[1]) res = DIR_DOWN;
    else if (req[2]) res = DIR_LEFT;
    else if (req[3]) res = DIR_RIGHT;
    else             res = 4'b0000;
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: synchroniser chain, stability counter, accepted level and a
// registered one-cycle pulse on each accepted rising edge.
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   stable_prev_q;
  logic                   press_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Any sample that agrees with the accepted level restarts the count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = synced;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= '0;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      press_q       <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], key_i};
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      press_q       <= stable_q & ~stable_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/key_direction_ctrl.sv
// Turns four raw buttons into a committed snake direction and a periodic step pulse,
// rejecting 180-degree reversals against the committed direction.
module key_direction_ctrl
  import snake_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int STEP_CYCLES     = 6500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       game_over,
  output logic [3:0] dir,
  output logic       step,
  output logic       running,
  output logic [3:0] press
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  state_e        state_q;
  logic [3:0]    dir_q;
  logic [3:0]    pending_q;
  logic [SW-1:0] step_cnt_q;
  logic          step_q;
  logic          running_q;

  logic [3:0]    winner;
  logic          req;
  logic          reject;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .key_i   (key[i]),
      .press_o (press[i])
    );
  end

  always_comb begin
    winner = priority_pick(press);
    req    = |press;
    reject = (winner == opposite(dir_q));
  end

  // dir follows pending on the cycle step is high, so the new heading shows one
  // cycle after the pulse; a press in that same cycle is judged against the old dir.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_RIGHT;
      pending_q  <= DIR_RIGHT;
      step_cnt_q <= '0;
      step_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          step_q     <= 1'b0;
          step_cnt_q <= '0;
          if (req) begin
            dir_q     <= winner;
            pending_q <= winner;
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (game_over) begin
            state_q    <= ST_IDLE;
            running_q  <= 1'b0;
            dir_q      <= DIR_RIGHT;
            pending_q  <= DIR_RIGHT;
            step_cnt_q <= '0;
            step_q     <= 1'b0;
          end else begin
            if (step_cnt_q == STEP_LAST) begin
              step_cnt_q <= '0;
              step_q     <= 1'b1;
            end else begin
              step_cnt_q <= step_cnt_q + SW'(1);
              step_q     <= 1'b0;
            end
            if (step_q) dir_q <= pending_q;
            if (req && !reject) pending_q <= winner;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          step_q    <= 1'b0;
        end
      endcase
    end
  end

  assign dir     = dir_q;
  assign step    = step_q;
  assign running = running_q;

endmodule
